uart_frame_decoder: RTL

UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

---
 rtl/uart_frame_pkg.sv | 33 +++
 rtl/entry_fifo.sv | 51 +++++
 rtl/uart_frame_decoder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types for the UART sparse-matrix frame decoder: FSM states, error codes and the
// entry record pushed into the output FIFO.
package uart_frame_pkg;

  localparam logic [7:0] SyncDefault = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StCount,
    StRow,
    StCol,
    StValH,
    StValL,
    StCheck
  } state_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrChecksum = 2'd1,
    ErrOverflow = 2'd2,
    ErrTimeout  = 2'd3
  } err_e;

  typedef struct packed {
    logic [7:0]  row;
    logic [7:0]  col;
    logic [15:0] val;
    logic        last;
  } entry_t;

  localparam int unsigned EntryWidth = $bits(entry_t);

endpackage

// File: rtl/entry_fifo.sv
// Synchronous FIFO for decoded entries; a write into a full FIFO is accepted when a read
// happens on the same clock.
module entry_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [Width-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [Width-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW + 1)'(Depth));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  // Head reads as zero when empty so idle outputs are clean after reset.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_frame_decoder.sv
// Parses SYNC/N/entries/CHK frames from a byte stream into sparse-matrix entries, with
// checksum, overflow and inter-byte timeout reporting.
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = SyncDefault,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        entry_valid,
  input  logic        entry_ready,
  output logic [7:0]  entry_row,
  output logic [7:0]  entry_col,
  output logic [15:0] entry_val,
  output logic        entry_last,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  state_e         state_q, state_d;
  logic [7:0]     remaining_q, remaining_d;
  logic [7:0]     chk_q, chk_d;
  logic [7:0]     row_q, row_d, col_q, col_d, valh_q, valh_d;
  logic           ovf_q, ovf_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic           done_q, done_d, err_q, err_d;
  err_e           code_q, code_d;

  logic           fifo_wr, fifo_rd, fifo_full, fifo_empty;
  entry_t         wr_entry, head;

  assign wr_entry = '{row: row_q, col: col_q, val: {valh_q, rx_data},
                      last: (remaining_q == 8'd1)};
  assign fifo_rd  = entry_valid && entry_ready;

  entry_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (EntryWidth)
  ) u_entry_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (fifo_wr),
    .wr_data (wr_entry),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data (head),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    chk_d       = chk_q;
    row_d       = row_q;
    col_d       = col_q;
    valh_d      = valh_q;
    ovf_d       = ovf_q;
    tmo_d       = tmo_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    code_d      = ErrNone;
    fifo_wr     = 1'b0;
    if (state_q != StIdle) tmo_d = tmo_q + 1'b1;
    if (rx_valid) begin
      tmo_d = '0;
      unique case (state_q)
        StIdle: begin
          if (rx_data == SYNC_BYTE) begin
            state_d = StCount;
            chk_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        StCount: begin
          remaining_d = rx_data;
          chk_d       = rx_data;
          state_d     = (rx_data == 8'd0) ? StCheck : StRow;
        end
        StRow: begin
          row_d   = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = StCol;
        end
        StCol: begin
          col_d   = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = StValH;
        end
        StValH: begin
          valh_d  = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = StValL;
        end
        StValL: begin
          chk_d       = chk_q ^ rx_data;
          fifo_wr     = 1'b1;
          // Matches the FIFO's accept rule: full is only a drop without a same-cycle read.
          if (fifo_full && !fifo_rd) ovf_d = 1'b1;
          remaining_d = remaining_q - 8'd1;
          state_d     = (remaining_q == 8'd1) ? StCheck : StRow;
        end
        StCheck: begin
          state_d = StIdle;
          if (ovf_q) begin
            err_d  = 1'b1;
            code_d = ErrOverflow;
          end else if (chk_q != rx_data) begin
            err_d  = 1'b1;
            code_d = ErrChecksum;
          end else begin
            done_d = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle && tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
      state_d = StIdle;
      tmo_d   = '0;
      err_d   = 1'b1;
      code_d  = ErrTimeout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      chk_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      valh_q      <= '0;
      ovf_q       <= 1'b0;
      tmo_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ErrNone;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      chk_q       <= chk_d;
      row_q       <= row_d;
      col_q       <= col_d;
      valh_q      <= valh_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
      done_q      <= done_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign entry_valid = !fifo_empty;
  assign entry_row   = head.row;
  assign entry_col   = head.col;
  assign entry_val   = head.val;
  assign entry_last  = head.last;
  assign frame_done  = done_q;
  assign frame_err   = err_q;
  assign err_code    = code_q;
  assign busy        = (state_q != StIdle);

endmodule
